plot_scheduler: RTL
===================

# plot_scheduler

Shares the single VGA pixel-write port (VGA_X, VGA_Y, VGA_COLOR, plot) among three rectangle-drawing requesters, such as the tile scroller, the lane/background eraser and the score/status painter. It arbitrates round-robin, latches the winning rectangle, and scans it one pixel per clock. Pixels outside the 160x120 screen are suppressed. The block sits between the game logic and the top-level VGA outputs inside the display hierarchy.

## Interface
- XMAX, 159, largest on-screen x; larger x is clipped
- YMAX, 119, largest on-screen y; larger y is clipped
- CLOCK_50  in  1  system clock, all state on rising edge
- Resetn  in  1  asynchronous active-low reset
- req  in  3  req[i] = requester i wants a rectangle drawn
- rect_x  in  24  x origin, 8 bits per requester, requester i at [8i+7:8i]
- rect_y  in  21  y origin, 7 bits per requester at [7i+6:7i]
- rect_w  in  24  width in pixels, 8 bits per requester; 0 = empty
- rect_h  in  21  height in pixels, 7 bits per requester; 0 = empty
- rect_color  in  9  color, 3 bits per requester at [3i+2:3i]
- grant  out  3  one-cycle one-hot pulse: request i accepted, fields captured
- done  out  3  one-cycle one-hot pulse: rectangle of requester i finished
- busy  out  1  high whenever state is not IDLE
- VGA_X  out  8  pixel x
- VGA_Y  out  7  pixel y
- VGA_COLOR  out  3  pixel color
- plot  out  1  write strobe for VGA_X/VGA_Y/VGA_COLOR

## Operation
- FSM states are IDLE, DRAW and FINISH. All outputs are registered.
- Reset state:
  - state = IDLE, round-robin pointer = 0.
  - grant = 0, done = 0, busy = 0, plot = 0.
  - VGA_X = 0, VGA_Y = 0, VGA_COLOR = 0.
- IDLE with req != 0:
  - The winner is the first set req bit, searching from the pointer upward and wrapping mod 3.
  - Latch the winner's x, y, w, h and color; set grant[winner] = 1; set pointer = (winner+1) mod 3.
  - Clear the column counter cx and the row counter cy.
  - Go to DRAW, or straight to FINISH if w == 0 or h == 0.
- DRAW, each cycle:
  - Compute px = x + cx (9-bit) and py = y + cy (8-bit).
  - Register VGA_X = px[7:0], VGA_Y = py[6:0] and VGA_COLOR = color.
  - plot = 1 only if px <= XMAX and py <= YMAX. A clipped pixel still consumes its cycle with plot = 0.
  - If cx == w-1: set cx = 0 and increment cy. Otherwise increment cx.
  - On the last pixel (cx == w-1 and cy == h-1), go to FINISH.
- FINISH: set plot = 0, done[winner] = 1, return to IDLE.
- Scan order is row-major: x fastest, then y.
- grant and done are each high for exactly one cycle. They are never both high for the same requester in the same cycle.
- The block samples req only in IDLE. A req dropped before grant is ignored, with no partial draw. Requester fields may change freely after grant.
- A requester may keep req high after done to be granted again. It is still subject to the round-robin pointer.

## Timing
- Let IDLE sample req at edge k, with P = w*h.
  - grant is high in cycle k+1.
  - Pixels appear at edges k+1 through k+P, one per cycle, with no gaps.
  - done is high after edge k+P+1.
  - The next grant can occur at edge k+P+2.
- Throughput is P+2 cycles per rectangle.
- An empty rectangle gives grant after edge k and done after edge k+1, with plot never asserted.
- Resetn low at any time, including mid-DRAW: all outputs reach their reset values immediately. The aborted rectangle receives no done.
- Counter widths are 8 bits for cx and 7 bits for cy. Maximum P = 255*127 with no counter overflow.

## Test plan
- Single request, req = 3'b001, x = 10, y = 20, w = 3, h = 2, color = 5:
  - grant = 001 for one cycle.
  - plot is high for 6 consecutive cycles at (10,20), (11,20), (12,20), (10,21), (11,21), (12,21), all with color 5.
  - done = 001 exactly 1 cycle after the last pixel.
- Contention, req = 3'b111 held continuously, all w = h = 1:
  - Grant order is 0, 1, 2, 0.
  - Each grant is 3 cycles apart.
- Clipping, x = 158, y = 119, w = 4, h = 2:
  - 8 pixel cycles; plot = 1 only for (158,119) and (159,119).
  - done still pulses.
- Zero size, w = 0, h = 5:
  - grant, then done on the next cycle.
  - plot never asserted; busy high for one cycle.
- Mid-draw reset during w = 10, h = 10:
  - Pulse Resetn low for 1 cycle at pixel 37.
  - plot, busy and done go to 0 immediately; the pointer returns to 0.
  - A fresh req = 3'b110 is granted to requester 1.
- Withdrawn request: req[2] pulsed high while busy with requester 0 and low again before done. Requester 2 is never granted.

Source files
------------

// File: rtl/plot_scheduler.sv
// Round-robin arbiter that lets three rectangle requesters share one VGA pixel-write port,
// scanning the granted rectangle row-major at one pixel per clock and clipping to 160x120.
module plot_scheduler #(
    parameter int XMAX = 159,
    parameter int YMAX = 119
) (
    input  logic        CLOCK_50,
    input  logic        Resetn,
    input  logic [2:0]  req,
    input  logic [23:0] rect_x,
    input  logic [20:0] rect_y,
    input  logic [23:0] rect_w,
    input  logic [20:0] rect_h,
    input  logic [8:0]  rect_color,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic        busy,
    output logic [7:0]  VGA_X,
    output logic [6:0]  VGA_Y,
    output logic [2:0]  VGA_COLOR,
    output logic        plot
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRAW   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [8:0] X_LIMIT = 9'(XMAX);
    localparam logic [7:0] Y_LIMIT = 8'(YMAX);

    logic [1:0] state;
    logic [1:0] ptr;
    logic [1:0] owner;
    logic [7:0] x_reg;
    logic [6:0] y_reg;
    logic [7:0] w_reg;
    logic [6:0] h_reg;
    logic [2:0] color_reg;
    logic [7:0] cx;
    logic [6:0] cy;

    logic [7:0] in_x [3];
    logic [6:0] in_y [3];
    logic [7:0] in_w [3];
    logic [6:0] in_h [3];
    logic [2:0] in_c [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_unpack
            assign in_x[gi] = rect_x[8*gi +: 8];
            assign in_y[gi] = rect_y[7*gi +: 7];
            assign in_w[gi] = rect_w[8*gi +: 8];
            assign in_h[gi] = rect_h[7*gi +: 7];
            assign in_c[gi] = rect_color[3*gi +: 3];
        end
    endgenerate

    // Search starts at the pointer and wraps modulo 3; first set bit wins.
    logic       found;
    logic [1:0] win_idx;
    logic [2:0] cand_sum;

    always_comb begin
        found    = 1'b0;
        win_idx  = 2'd0;
        cand_sum = 3'd0;
        for (int k = 0; k < 3; k++) begin
            cand_sum = {1'b0, ptr} + 3'(k);
            if (cand_sum >= 3'd3) begin
                cand_sum = cand_sum - 3'd3;
            end
            if (!found && req[cand_sum[1:0]]) begin
                found   = 1'b1;
                win_idx = cand_sum[1:0];
            end
        end
    end

    logic [8:0] px;
    logic [7:0] py;
    assign px = {1'b0, x_reg} + {1'b0, cx};
    assign py = {1'b0, y_reg} + {1'b0, cy};

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            owner     <= 2'd0;
            x_reg     <= 8'd0;
            y_reg     <= 7'd0;
            w_reg     <= 8'd0;
            h_reg     <= 7'd0;
            color_reg <= 3'd0;
            cx        <= 8'd0;
            cy        <= 7'd0;
            grant     <= 3'd0;
            done      <= 3'd0;
            busy      <= 1'b0;
            plot      <= 1'b0;
            VGA_X     <= 8'd0;
            VGA_Y     <= 7'd0;
            VGA_COLOR <= 3'd0;
        end else begin
            grant <= 3'd0;
            done  <= 3'd0;
            plot  <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        owner     <= win_idx;
                        x_reg     <= in_x[win_idx];
                        y_reg     <= in_y[win_idx];
                        w_reg     <= in_w[win_idx];
                        h_reg     <= in_h[win_idx];
                        color_reg <= in_c[win_idx];
                        grant     <= 3'b001 << win_idx;
                        ptr       <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
                        cx        <= 8'd0;
                        cy        <= 7'd0;
                        busy      <= 1'b1;
                        // Empty rectangles skip DRAW so plot is never raised for them.
                        if (in_w[win_idx] == 8'd0 || in_h[win_idx] == 7'd0) begin
                            state <= FINISH;
                        end else begin
                            state <= DRAW;
                        end
                    end
                end
                DRAW: begin
                    VGA_X     <= px[7:0];
                    VGA_Y     <= py[6:0];
                    VGA_COLOR <= color_reg;
                    plot      <= (px <= X_LIMIT) && (py <= Y_LIMIT);
                    if (cx == w_reg - 8'd1) begin
                        cx <= 8'd0;
                        cy <= cy + 7'd1;
                        if (cy == h_reg - 7'd1) begin
                            state <= FINISH;
                        end
                    end else begin
                        cx <= cx + 8'd1;
                    end
                end
                FINISH: begin
                    done  <= 3'b001 << owner;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
